k_fftsequencer: RTL and testbench



---
 rtl/p_memfuncs.sv | 28 ++
 rtl/k_fftaddrgen.sv | 35 +++
 rtl/k_fftsequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_k_fftsequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_memfuncs.sv
// Shared helpers for the FFT control slice.
//   clogb2 : ceil(log2(value)), usable in parameter expressions
//   bitrev : reverse the low 'width' bits of a value (width <= MaxLog2)
//   t_fftseq_state : frame sequencer states
package p_memfuncs;

    localparam int unsigned MaxLog2 = 12;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} t_fftseq_state;

    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Full-width reverse, then shift the reversed field down to bit 0.
    function automatic logic [MaxLog2-1:0] bitrev(input logic [MaxLog2-1:0] value,
                                                  input int unsigned width);
        logic [MaxLog2-1:0] rf;
        rf = {<<{value}};
        return rf >> (MaxLog2 - width);
    endfunction

endpackage

// File: rtl/k_fftaddrgen.sv
// Combinational butterfly address generator for an in-place radix-2 DIT FFT.
//   stage_i    : stage s (0..LOG2N-1)
//   bfly_i     : butterfly b within the stage (0..N/2-1)
//   i0_o, i1_o : the two RAM indices of the butterfly (i1 = i0 + 2^s)
//   rom_addr_o : twiddle index (b mod 2^s) << (LOG2N-1-s)
module k_fftaddrgen #(
    parameter int unsigned LOG2N = 4
) (
    input  logic [LOG2N-1:0] stage_i,
    input  logic [LOG2N-2:0] bfly_i,
    output logic [LOG2N-1:0] i0_o,
    output logic [LOG2N-1:0] i1_o,
    output logic [LOG2N-2:0] rom_addr_o
);

    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] low_mask;
    logic [LOG2N-1:0] high_part;
    logic [LOG2N-1:0] i0;

    always_comb begin
        b_ext     = {1'b0, bfly_i};
        span      = LOG2N'(1) << stage_i;
        low_mask  = span - LOG2N'(1);
        // Insert a zero at bit s of b: upper bits move up one, low s bits stay.
        high_part = (b_ext >> stage_i) << (stage_i + LOG2N'(1));
        i0        = high_part | (b_ext & low_mask);
        i0_o      = i0;
        i1_o      = i0 | span;
        // Truncation drops the bits of b above s, leaving pos << (LOG2N-1-s).
        rom_addr_o = bfly_i << (LOG2N'(LOG2N - 1) - stage_i);
    end

endmodule

// File: rtl/k_fftsequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT datapath (RAM, butterfly,
// twiddle ROM, write/output muxes). Carries no data.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   scale_sch            : per-stage scaling, latched on the first sample accept
//   s_axis_data_*        : input sample handshake (samples written bit-reversed)
//   m_axis_data_*        : output stream handshake (natural order, tlast on N-1)
//   addr0/1, en0/1       : RAM port A/B address and write enable
//   rst0/1               : RAM output-register reset (held while idle)
//   sel0/1               : write-data mux, 1 = input sample, 0 = butterfly
//   sel2                 : output mux, 1 = out0
//   rom_addr, scaling    : twiddle index and scaling of the current stage
// Optional: define K_FFTSEQ_FRAMEERR_EN to add s_axis_data_tlast and the
// event_tlast_unexpected / event_tlast_missing one-cycle pulses.
module k_fftsequencer
    import p_memfuncs::*;
#(
    parameter int unsigned  TRANSFORM_LENGTH = 16,
    localparam int unsigned LOG2N = clogb2(TRANSFORM_LENGTH)
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [2*LOG2N-1:0] scale_sch,
    input  logic               s_axis_data_tvalid,
    output logic               s_axis_data_tready,
    output logic               m_axis_data_tvalid,
    input  logic               m_axis_data_tready,
    output logic               m_axis_data_tlast,
`ifdef K_FFTSEQ_FRAMEERR_EN
    input  logic               s_axis_data_tlast,
    output logic               event_tlast_unexpected,
    output logic               event_tlast_missing,
`endif
    output logic [LOG2N-1:0]   addr0,
    output logic [LOG2N-1:0]   addr1,
    output logic               en0,
    output logic               en1,
    output logic               rst0,
    output logic               rst1,
    output logic               sel0,
    output logic               sel1,
    output logic               sel2,
    output logic [LOG2N-2:0]   rom_addr,
    output logic [1:0]         scaling
);

    localparam logic [LOG2N-1:0] LastIdx   = LOG2N'(TRANSFORM_LENGTH - 1);
    localparam logic [LOG2N-1:0] LastStage = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-2:0] LastBfly  = '1;

    t_fftseq_state      state_q, state_d;
    logic [LOG2N-1:0]   k_q, k_d;
    logic [LOG2N-1:0]   stage_q, stage_d;
    logic [LOG2N-2:0]   bfly_q, bfly_d;
    logic               wr_q, wr_d;       // 0 = READ, 1 = WRITE half of a butterfly
    logic [LOG2N-1:0]   j_q, j_d;
    logic               mvalid_q, mvalid_d;
    logic               sready_q, sready_d;
    logic [2*LOG2N-1:0] sched_q, sched_d;

    logic               s_hs;
    logic               m_hs;
    logic [LOG2N-1:0]   bf_i0;
    logic [LOG2N-1:0]   bf_i1;
    logic [LOG2N-2:0]   bf_rom;

    assign s_hs = s_axis_data_tvalid & sready_q;
    assign m_hs = mvalid_q & m_axis_data_tready;

    k_fftaddrgen #(
        .LOG2N(LOG2N)
    ) u_addrgen (
        .stage_i   (stage_q),
        .bfly_i    (bfly_q),
        .i0_o      (bf_i0),
        .i1_o      (bf_i1),
        .rom_addr_o(bf_rom)
    );

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        wr_d     = wr_q;
        j_d      = j_q;
        mvalid_d = mvalid_q;
        sched_d  = sched_q;

        unique case (state_q)
            IDLE: begin
                if (s_hs) begin
                    sched_d = scale_sch;
                    k_d     = LOG2N'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (s_hs) begin
                    if (k_q == LastIdx) begin
                        k_d     = '0;
                        stage_d = '0;
                        bfly_d  = '0;
                        wr_d    = 1'b0;
                        state_d = COMPUTE;
                    end else begin
                        k_d = k_q + LOG2N'(1);
                    end
                end
            end
            COMPUTE: begin
                wr_d = ~wr_q;
                if (wr_q) begin
                    if (bfly_q == LastBfly) begin
                        bfly_d = '0;
                        if (stage_q == LastStage) begin
                            stage_d  = '0;
                            j_d      = '0;
                            mvalid_d = 1'b0;
                            state_d  = UNLOAD;
                        end else begin
                            stage_d = stage_q + LOG2N'(1);
                        end
                    end else begin
                        bfly_d = bfly_q + (LOG2N-1)'(1);
                    end
                end
            end
            UNLOAD: begin
                // First UNLOAD cycle only prefetches address 0.
                if (!mvalid_q) begin
                    mvalid_d = 1'b1;
                end else if (m_hs) begin
                    if (j_q == LastIdx) begin
                        j_d      = '0;
                        mvalid_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        j_d = j_q + LOG2N'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tready is registered so it drops the cycle after the last accept.
        sready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            k_q      <= '0;
            stage_q  <= '0;
            bfly_q   <= '0;
            wr_q     <= 1'b0;
            j_q      <= '0;
            mvalid_q <= 1'b0;
            sready_q <= 1'b0;
            sched_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            wr_q     <= wr_d;
            j_q      <= j_d;
            mvalid_q <= mvalid_d;
            sready_q <= sready_d;
            sched_q  <= sched_d;
        end
    end

    // Control decode. Write enables and addresses follow the live handshake,
    // since write data and the RAM read pipeline are not delayed.
    always_comb begin
        addr0    = '0;
        addr1    = '0;
        en0      = 1'b0;
        en1      = 1'b0;
        rst0     = 1'b0;
        rst1     = 1'b0;
        sel0     = 1'b1;
        sel1     = 1'b1;
        sel2     = 1'b0;
        rom_addr = '0;
        scaling  = '0;

        unique case (state_q)
            IDLE, LOAD: begin
                // k_q is 0 while idle, so sample 0 lands at address 0.
                addr0 = LOG2N'(bitrev(MaxLog2'(k_q), LOG2N));
                en0   = s_hs;
                rst0  = (state_q == IDLE);
                rst1  = (state_q == IDLE);
            end
            COMPUTE: begin
                sel0     = 1'b0;
                sel1     = 1'b0;
                addr0    = bf_i0;
                addr1    = bf_i1;
                en0      = wr_q;
                en1      = wr_q;
                rom_addr = bf_rom;
                scaling  = 2'(sched_q >> {stage_q, 1'b0});
            end
            UNLOAD: begin
                sel2  = 1'b1;
                // Advance the read address only on a handshake so out0 holds under stall.
                addr0 = m_hs ? (j_q + LOG2N'(1)) : j_q;
            end
            default: ;
        endcase
    end

    assign s_axis_data_tready = sready_q;
    assign m_axis_data_tvalid = mvalid_q;
    assign m_axis_data_tlast  = mvalid_q && (j_q == LastIdx);

`ifdef K_FFTSEQ_FRAMEERR_EN
    logic evt_unexp_q;
    logic evt_miss_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            evt_unexp_q <= 1'b0;
            evt_miss_q  <= 1'b0;
        end else begin
            evt_unexp_q <= s_hs && s_axis_data_tlast && (k_q != LastIdx);
            evt_miss_q  <= s_hs && !s_axis_data_tlast && (k_q == LastIdx);
        end
    end

    assign event_tlast_unexpected = evt_unexp_q;
    assign event_tlast_missing    = evt_miss_q;
`endif

endmodule

// File: tb/tb_k_fftsequencer.sv
// Self-checking bench for k_fftsequencer (N = 16). A behavioural RAM and an
// integer stand-in butterfly are driven by the DUT controls; the reference
// runs the same in-place algorithm directly on natural indices.
module tb_k_fftsequencer;

    localparam int unsigned N  = 16;
    localparam int unsigned L  = 4;
    localparam int unsigned NL = N * L;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [2*L-1:0] scale_sch;
    logic           s_tvalid;
    logic           s_tready;
    logic           m_tvalid;
    logic           m_tready;
    logic           m_tlast;
    logic [L-1:0]   addr0;
    logic [L-1:0]   addr1;
    logic           en0, en1, rst0, rst1, sel0, sel1, sel2;
    logic [L-2:0]   rom_addr;
    logic [1:0]     scaling;
    logic [31:0]    s_tdata;

    int checks = 0;
    int errors = 0;
    int tl_pos = N - 1;

    always #5 aclk = ~aclk;

`ifdef K_FFTSEQ_FRAMEERR_EN
    logic s_tlast;
    logic ev_unexp;
    logic ev_miss;
    int   n_unexp = 0;
    int   n_miss  = 0;
    always @(posedge aclk) begin
        if (ev_unexp) n_unexp <= n_unexp + 1;
        if (ev_miss)  n_miss  <= n_miss + 1;
    end
`endif

    k_fftsequencer #(
        .TRANSFORM_LENGTH(N)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .scale_sch         (scale_sch),
        .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready),
        .m_axis_data_tvalid(m_tvalid),
        .m_axis_data_tready(m_tready),
        .m_axis_data_tlast (m_tlast),
`ifdef K_FFTSEQ_FRAMEERR_EN
        .s_axis_data_tlast     (s_tlast),
        .event_tlast_unexpected(ev_unexp),
        .event_tlast_missing   (ev_miss),
`endif
        .addr0             (addr0),
        .addr1             (addr1),
        .en0               (en0),
        .en1               (en1),
        .rst0              (rst0),
        .rst1              (rst1),
        .sel0              (sel0),
        .sel1              (sel1),
        .sel2              (sel2),
        .rom_addr          (rom_addr),
        .scaling           (scaling)
    );

    // Datapath stand-in: dual-port RAM with registered read, integer butterfly.
    logic [31:0] mem [N];
    logic [31:0] out0, out1, bf0, bf1, w_mul, dout;

    always_comb begin
        w_mul = 32'(rom_addr) + 32'd3;
        bf0   = (out0 + out1 * w_mul) >> scaling;
        bf1   = (out0 - out1 * w_mul) >> scaling;
        dout  = sel2 ? out0 : out1;
    end

    always @(posedge aclk) begin
        out0 <= rst0 ? 32'd0 : mem[addr0];
        out1 <= rst1 ? 32'd0 : mem[addr1];
        if (en0) mem[addr0] <= sel0 ? s_tdata : bf0;
        if (en1) mem[addr1] <= sel1 ? s_tdata : bf1;
    end

    logic [31:0] in_smp  [N];
    logic [31:0] exp_out [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned rev_idx(input int unsigned v);
        int unsigned r = 0;
        for (int i = 0; i < L; i++) r = r * 2 + ((v / (2 ** i)) % 2);
        return r;
    endfunction

    function automatic logic next_ready(input int rmode, input int seq);
        if (rmode == 0) return ((seq % 4) == 0) || ((seq % 4) == 3);
        return $urandom_range(1, 100) <= rmode;
    endfunction

    // Reference: bit-reversed load, then log2(N) stages of in-place butterflies.
    task automatic ref_fft(input logic [2*L-1:0] sch);
        logic [31:0] x [N];
        logic [31:0] a, c, w;
        int span, i0, i1, sc;
        for (int k = 0; k < N; k++) x[rev_idx(k)] = in_smp[k];
        for (int s = 0; s < L; s++) begin
            span = 2 ** s;
            sc   = (int'(sch) / (4 ** s)) % 4;
            for (int b = 0; b < N / 2; b++) begin
                i0 = (b / span) * 2 * span + b % span;
                i1 = i0 + span;
                w  = 32'((b % span) * (N / 2 / span)) + 32'd3;
                a  = x[i0];
                c  = x[i1];
                x[i0] = (a + c * w) >> sc;
                x[i1] = (a - c * w) >> sc;
            end
        end
        for (int k = 0; k < N; k++) exp_out[k] = x[k];
    endtask

    task automatic check_reset_vals();
        check_eq("rst_ctl", {en0, en1, rst0, rst1, sel0, sel1, sel2, m_tvalid, m_tlast, s_tready},
                 10'b0011110000);
        check_eq("rst_addr", {addr0, addr1}, 0);
        check_eq("rst_rom_scl", {rom_addr, scaling}, 0);
    endtask

    task automatic run_frame(input logic [2*L-1:0] sch, input int vpct, input int rmode,
                             input int rst_at);
        int  k, lat, j, rseq, c, bi, s, b, span, i0, tw;
        bit  got;
`ifdef K_FFTSEQ_FRAMEERR_EN
        int  u0, m0;
        u0 = n_unexp;
        m0 = n_miss;
`endif
        for (int i = 0; i < N; i++) in_smp[i] = $urandom;
        ref_fft(sch);

        // Load
        k = 0;
        lat = 0;
        m_tready = 1'b0;
        while (k < N && lat < 20 * N) begin
            @(posedge aclk);
            #1;
            s_tvalid  = ($urandom_range(1, 100) <= vpct);
            s_tdata   = s_tvalid ? in_smp[k] : $urandom;
            scale_sch = (k == 0) ? sch : sch ^ 8'($urandom);
`ifdef K_FFTSEQ_FRAMEERR_EN
            s_tlast   = s_tvalid && (k == tl_pos);
`endif
            @(negedge aclk);
            lat++;
            check_eq("load_tready", s_tready, 1);
            check_eq("load_en0", en0, s_tvalid);
            if (s_tvalid) begin
                check_eq("load_addr0", addr0, rev_idx(k));
                check_eq("load_sel0", sel0, 1);
                k++;
            end
        end
        if (k < N) check_eq("load_timeout", k, N);

        // Compute, up to the first output valid
        lat  = 0;
        got  = 1'b0;
        rseq = 0;
        while (!got && lat < NL + 8) begin
            @(posedge aclk);
            #1;
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            m_tready = next_ready(rmode, rseq);
            rseq++;
            @(negedge aclk);
            lat++;
            check_eq("busy_tready", s_tready, 0);
            if (m_tvalid) begin
                got = 1'b1;
            end else if (lat <= NL) begin
                c    = lat - 1;
                bi   = c / 2;
                s    = bi / (N / 2);
                b    = bi % (N / 2);
                span = 2 ** s;
                i0   = (b / span) * 2 * span + b % span;
                tw   = (b % span) * (N / 2 / span);
                check_eq("cmp_addr0", addr0, i0);
                check_eq("cmp_addr1", addr1, i0 + span);
                check_eq("cmp_rom", rom_addr, tw);
                check_eq("cmp_scaling", scaling, (int'(sch) / (4 ** s)) % 4);
                check_eq("cmp_en", {en0, en1}, (c % 2 == 1) ? 2'b11 : 2'b00);
                check_eq("cmp_sel", {sel0, sel1}, 0);
                if (s == 1 && b == 5 && c % 2 == 0) begin
                    check_eq("s1b5_addrs", {addr0, addr1, rom_addr}, {4'd9, 4'd11, 3'd4});
                end
                if (c == rst_at) begin
                    aresetn  = 1'b0;
                    #1;
                    check_reset_vals();
                    s_tvalid = 1'b0;
                    repeat (2) @(posedge aclk);
                    #1;
                    check_reset_vals();
                    @(negedge aclk);
                    aresetn = 1'b1;
                    return;
                end
            end
        end
        check_eq("latency", lat, NL + 2);

        // Unload
        j = 0;
        lat = 0;
        while (got && j < N && lat < 20 * N) begin
            check_eq("ul_tvalid", m_tvalid, 1);
            check_eq("ul_data", dout, exp_out[j]);
            check_eq("ul_tlast", m_tlast, (j == N - 1));
            check_eq("ul_sel2", sel2, 1);
            check_eq("ul_addr0", addr0, m_tready ? (j + 1) % N : j);
            check_eq("ul_s_side", {s_tready, en0}, 0);
            if (m_tready) j++;
            @(posedge aclk);
            #1;
            m_tready = next_ready(rmode, rseq);
            rseq++;
            s_tvalid = 1'($urandom_range(0, 1));
            @(negedge aclk);
            lat++;
        end
        check_eq("ul_count", j, N);
        check_eq("ul_end_tvalid", m_tvalid, 0);
        check_eq("ul_end_tlast", m_tlast, 0);
        check_eq("idle_tready", s_tready, 1);
        s_tvalid = 1'b0;
`ifdef K_FFTSEQ_FRAMEERR_EN
        check_eq("ev_unexpected", n_unexp - u0, (tl_pos != N - 1) ? 1 : 0);
        check_eq("ev_missing", n_miss - m0, (tl_pos != N - 1) ? 1 : 0);
`endif
    endtask

    initial begin
        aresetn   = 1'b0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;
        s_tdata   = '0;
        scale_sch = '0;
`ifdef K_FFTSEQ_FRAMEERR_EN
        s_tlast   = 1'b0;
`endif
        repeat (2) @(posedge aclk);
        #1;
        check_reset_vals();
        @(negedge aclk);
        aresetn = 1'b1;

        run_frame(8'h1B, 100, 0, -1);
        run_frame(8'($urandom), 60, 70, 40);
        tl_pos = 9;
        run_frame(8'($urandom), 50, 50, -1);
        tl_pos = N - 1;
        run_frame(8'h00, 100, 100, -1);
        run_frame(8'($urandom), 80, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
